obstacle_scheduler: RTL and testbench

OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

---
 rtl/obstacle_scheduler_pkg.sv | 39 +++
 rtl/obstacle_slot.sv | 53 +++++
 rtl/obstacle_scheduler.sv | 101 ++++++++++
 tb/tb_obstacle_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_scheduler_pkg.sv
// Shared types and default geometry for the obstacle scheduler and its slot registers.
// Slot type encoding, game state codes and default X/Y constants live here.
package obstacle_scheduler_pkg;

   typedef enum logic [1:0] {
      OBS_NONE  = 2'd0,
      OBS_HIGH1 = 2'd1,
      OBS_LOW2  = 2'd2,
      OBS_LOW3  = 2'd3
   } obs_type_t;

   // Player/game state codes shared with the rest of the game logic.
   typedef enum logic [2:0] {
      RUN1  = 3'd0,
      RUN2  = 3'd1,
      JUMP  = 3'd2,
      DUCK1 = 3'd3,
      DUCK2 = 3'd4,
      FAIL1 = 3'd5,
      FAIL2 = 3'd6
   } game_state_t;

   localparam int DEF_COOLDOWN = 18;
   localparam int DEF_X_START  = 780;
   localparam int DEF_X_END    = 80;
   localparam int DEF_Y_HIGH_A = 160;
   localparam int DEF_Y_HIGH_B = 200;
   localparam int DEF_Y_LOW    = 245;

   // Both rand codes 0 and 1 give a single high obstacle; only the row differs.
   function automatic obs_type_t type_from_rand(input logic [1:0] sel);
      case (sel)
         2'd0, 2'd1: type_from_rand = OBS_HIGH1;
         2'd2:       type_from_rand = OBS_LOW2;
         default:    type_from_rand = OBS_LOW3;
      endcase
   endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One obstacle slot: occupied flag, type, and sprite origin.
// Allocate, scroll, retire and clear are all applied on the clock edge.
module obstacle_slot
   import obstacle_scheduler_pkg::*;
#(
   parameter int X_START = DEF_X_START,
   parameter int X_END   = DEF_X_END
) (
   input  logic      CLK,
   input  logic      RESET,
   input  logic      clear,
   input  logic      alloc,
   input  logic      move,
   input  obs_type_t alloc_type,
   input  logic [9:0] alloc_y,
   output logic      busy,
   output obs_type_t kind,
   output logic [9:0] x,
   output logic [9:0] y
);

   localparam logic [9:0] XS = 10'(X_START);
   localparam logic [9:0] XE = 10'(X_END);

   // alloc is only raised on a free slot and move only acts on a busy one,
   // so the two never compete for the same slot in one cycle.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         busy <= 1'b0;
         kind <= OBS_NONE;
         x    <= XS;
         y    <= '0;
      end else if (clear) begin
         busy <= 1'b0;
         kind <= OBS_NONE;
         x    <= XS;
      end else if (alloc) begin
         busy <= 1'b1;
         kind <= alloc_type;
         x    <= XS;
         y    <= alloc_y;
      end else if (move && busy) begin
         if (x <= XE) begin
            busy <= 1'b0;
            kind <= OBS_NONE;
            x    <= XS;
         end else begin
            x <= x - 10'd1;
         end
      end
   end

endmodule

// File: rtl/obstacle_scheduler.sv
// Spawns obstacles into three slots after a spawn-tick cooldown and scrolls them left.
// Slots retire once they pass the left threshold and become free for later spawns.
module obstacle_scheduler
   import obstacle_scheduler_pkg::*;
#(
   parameter int COOLDOWN = DEF_COOLDOWN,
   parameter int X_START  = DEF_X_START,
   parameter int X_END    = DEF_X_END,
   parameter int Y_HIGH_A = DEF_Y_HIGH_A,
   parameter int Y_HIGH_B = DEF_Y_HIGH_B,
   parameter int Y_LOW    = DEF_Y_LOW
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            run,
   input  logic            clear,
   input  logic            tick_spawn,
   input  logic            tick_move,
   input  logic [12:0]     rand_val,
   output logic [2:0]      slot_busy,
   output logic [2:0][1:0] slot_type,
   output logic [2:0][9:0] slot_x,
   output logic [2:0][9:0] slot_y,
   output logic            spawn_pulse,
   output logic [1:0]      spawn_slot
);

   localparam logic [4:0] COOL_CNT = 5'(COOLDOWN);

   logic [4:0] cnt;
   logic [2:0] alloc;
   logic [1:0] free_idx;
   logic       any_free;
   logic       spawn_now;
   logic       move_now;
   obs_type_t  alloc_type;
   logic [9:0] alloc_y;
   logic       unused_rand_bits;

   assign unused_rand_bits = ^rand_val[12:2];

   // Free-slot search looks at the pre-edge busy flags, so a slot retiring
   // this cycle is not reused until a later spawn tick.
   always_comb begin
      any_free = ~&slot_busy;
      free_idx = 2'd0;
      if (!slot_busy[0])      free_idx = 2'd0;
      else if (!slot_busy[1]) free_idx = 2'd1;
      else                    free_idx = 2'd2;
      spawn_now  = run && !clear && tick_spawn && (cnt >= COOL_CNT) && any_free;
      move_now   = run && !clear && tick_move;
      alloc      = '0;
      if (spawn_now) alloc[free_idx] = 1'b1;
      alloc_type = type_from_rand(rand_val[1:0]);
      case (rand_val[1:0])
         2'd0:    alloc_y = 10'(Y_HIGH_A);
         2'd1:    alloc_y = 10'(Y_HIGH_B);
         default: alloc_y = 10'(Y_LOW);
      endcase
   end

   // Cooldown saturates at COOLDOWN while every slot is occupied.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt         <= '0;
         spawn_pulse <= 1'b0;
         spawn_slot  <= '0;
      end else if (clear) begin
         cnt         <= '0;
         spawn_pulse <= 1'b0;
      end else begin
         spawn_pulse <= spawn_now;
         if (spawn_now) begin
            cnt        <= '0;
            spawn_slot <= free_idx;
         end else if (run && tick_spawn && (cnt < COOL_CNT)) begin
            cnt <= cnt + 5'd1;
         end
      end
   end

   for (genvar i = 0; i < 3; i++) begin : g_slot
      obstacle_slot #(
         .X_START (X_START),
         .X_END   (X_END)
      ) u_slot (
         .CLK        (CLK),
         .RESET      (RESET),
         .clear      (clear),
         .alloc      (alloc[i]),
         .move       (move_now),
         .alloc_type (alloc_type),
         .alloc_y    (alloc_y),
         .busy       (slot_busy[i]),
         .kind       (slot_type[i]),
         .x          (slot_x[i]),
         .y          (slot_y[i])
      );
   end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler: directed scenarios followed by random
// stimulus, every cycle compared against a slot-list reference model.
module tb_obstacle_scheduler;

   logic            CLK;
   logic            RESET;
   logic            run;
   logic            clear;
   logic            tick_spawn;
   logic            tick_move;
   logic [12:0]     rand_val;
   logic [2:0]      slot_busy;
   logic [2:0][1:0] slot_type;
   logic [2:0][9:0] slot_x;
   logic [2:0][9:0] slot_y;
   logic            spawn_pulse;
   logic [1:0]      spawn_slot;

   obstacle_scheduler dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .run         (run),
      .clear       (clear),
      .tick_spawn  (tick_spawn),
      .tick_move   (tick_move),
      .rand_val    (rand_val),
      .slot_busy   (slot_busy),
      .slot_type   (slot_type),
      .slot_x      (slot_x),
      .slot_y      (slot_y),
      .spawn_pulse (spawn_pulse),
      .spawn_slot  (spawn_slot)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_checks = 0;
   int n_errors = 0;

   int m_busy [3];
   int m_type [3];
   int m_x    [3];
   int m_y    [3];
   int m_cnt;
   int m_pulse;
   int m_sslot;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_busy[i] = 0; m_type[i] = 0; m_x[i] = 780; m_y[i] = 0;
      end
      m_cnt = 0; m_pulse = 0; m_sslot = 0;
   endtask

   task automatic model_update(input bit r, input bit c, input bit ts, input bit tm,
                               input int rv);
      int pick;
      m_pulse = 0;
      if (c) begin
         for (int i = 0; i < 3; i++) begin
            m_busy[i] = 0; m_type[i] = 0; m_x[i] = 780;
         end
         m_cnt = 0;
      end else if (r) begin
         pick = -1;
         if (ts) begin
            if (m_cnt >= 18) begin
               for (int i = 2; i >= 0; i--) if (m_busy[i] == 0) pick = i;
               if (pick >= 0) m_cnt = 0;
            end else begin
               m_cnt++;
            end
         end
         if (tm) begin
            for (int i = 0; i < 3; i++) begin
               if (m_busy[i] != 0) begin
                  if (m_x[i] <= 80) begin
                     m_busy[i] = 0; m_type[i] = 0; m_x[i] = 780;
                  end else begin
                     m_x[i]--;
                  end
               end
            end
         end
         if (pick >= 0) begin
            m_busy[pick] = 1;
            m_x[pick]    = 780;
            case (rv % 4)
               0: begin m_type[pick] = 1; m_y[pick] = 160; end
               1: begin m_type[pick] = 1; m_y[pick] = 200; end
               2: begin m_type[pick] = 2; m_y[pick] = 245; end
               default: begin m_type[pick] = 3; m_y[pick] = 245; end
            endcase
            m_pulse = 1;
            m_sslot = pick;
         end
      end
   endtask

   task automatic compare_all();
      int bv;
      bv = m_busy[0] + 2 * m_busy[1] + 4 * m_busy[2];
      check("busy", int'(slot_busy), bv);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("type%0d", i), int'(slot_type[i]), m_type[i]);
         check($sformatf("x%0d", i), int'(slot_x[i]), m_x[i]);
         check($sformatf("y%0d", i), int'(slot_y[i]), m_y[i]);
      end
      check("spawn_pulse", int'(spawn_pulse), m_pulse);
      check("spawn_slot", int'(spawn_slot), m_sslot);
   endtask

   // Called at posedge+1; leaves inputs applied for exactly one edge.
   task automatic step(input bit r, input bit c, input bit ts, input bit tm, input int rv);
      run = r; clear = c; tick_spawn = ts; tick_move = tm; rand_val = 13'(rv);
      @(posedge CLK);
      model_update(r, c, ts, tm, rv);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      run = 1'b0; clear = 1'b0; tick_spawn = 1'b0; tick_move = 1'b0;
      RESET = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(posedge CLK);
      #1;
      RESET = 1'b0;
   endtask

   task automatic move_until_x0(input int target);
      int guard = 0;
      while (m_x[0] > target && guard < 1000) begin
         step(1, 0, 0, 1, 0);
         guard++;
      end
      check("wait_x0_bound", int'(guard < 1000), 1);
   endtask

   initial begin
      int guard;
      int pulses;
      int x_frozen;
      RESET = 1'b0; run = 1'b0; clear = 1'b0;
      tick_spawn = 1'b0; tick_move = 1'b0; rand_val = '0;
      #2;
      do_reset();

      // Cooldown: 18 ticks without spawn, the 19th spawns into slot 0.
      repeat (18) step(1, 0, 1, 0, 1);
      check("cd_no_spawn_busy", int'(slot_busy), 0);
      step(1, 0, 1, 0, 1);
      check("cd_pulse", int'(spawn_pulse), 1);
      check("cd_slot", int'(spawn_slot), 0);
      check("cd_x0", int'(slot_x[0]), 780);
      check("cd_type0", int'(slot_type[0]), 1);
      check("cd_y0", int'(slot_y[0]), 200);

      repeat (300) step(1, 0, 0, 1, 0);
      repeat (18) step(1, 0, 1, 0, 0);
      step(1, 0, 1, 0, 3);
      check("t3_slot", int'(spawn_slot), 1);
      check("t3_type1", int'(slot_type[1]), 3);
      check("t3_y1", int'(slot_y[1]), 245);

      repeat (100) step(1, 0, 0, 1, 0);
      repeat (19) step(1, 0, 1, 0, 2);
      check("full_busy", int'(slot_busy), 7);
      pulses = 0;
      repeat (25) begin
         step(1, 0, 1, 0, 0);
         pulses += int'(spawn_pulse);
      end
      check("full_no_pulse", pulses, 0);

      // Retire boundary on slot 0, with a spawn tick landing on the retiring edge.
      move_until_x0(81);
      check("x0_at_81", int'(slot_x[0]), 81);
      step(1, 0, 0, 1, 0);
      check("x0_at_80", int'(slot_x[0]), 80);
      check("x0_still_busy", int'(slot_busy[0]), 1);
      step(1, 0, 1, 1, 0);
      check("retire_busy0", int'(slot_busy[0]), 0);
      check("retire_x0", int'(slot_x[0]), 780);
      check("retire_no_pulse", int'(spawn_pulse), 0);
      step(1, 0, 1, 0, 0);
      check("realloc_pulse", int'(spawn_pulse), 1);
      check("realloc_slot", int'(spawn_slot), 0);

      // Saturated cooldown: the first tick after slot 1 retires allocates it.
      pulses = 0;
      repeat (25) begin
         step(1, 0, 1, 0, 0);
         pulses += int'(spawn_pulse);
      end
      check("sat_no_pulse", pulses, 0);
      guard = 0;
      while (m_busy[1] != 0 && guard < 1000) begin
         step(1, 0, 0, 1, 0);
         guard++;
      end
      check("wait_slot1_bound", int'(guard < 1000), 1);
      check("slot1_retired", int'(slot_busy[1]), 0);
      step(1, 0, 1, 0, 2);
      check("sat_pulse", int'(spawn_pulse), 1);
      check("sat_slot", int'(spawn_slot), 1);

      // clear with cnt=10 and slots busy.
      repeat (10) step(1, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      check("clr_busy", int'(slot_busy), 0);
      check("clr_x2", int'(slot_x[2]), 780);
      repeat (18) step(1, 0, 1, 0, 0);
      check("clr_cd_busy", int'(slot_busy), 0);
      step(1, 0, 1, 0, 0);
      check("clr_cd_pulse", int'(spawn_pulse), 1);

      // run=0 freezes the scroll.
      repeat (5) step(1, 0, 0, 1, 0);
      x_frozen = int'(slot_x[0]);
      check("pre_freeze_x0", x_frozen, 775);
      repeat (5) step(0, 0, 1, 1, 0);
      check("freeze_x0", int'(slot_x[0]), 775);

      // Asynchronous reset mid-operation.
      do_reset();
      check("rst_busy", int'(slot_busy), 0);
      check("rst_x0", int'(slot_x[0]), 780);

      for (int n = 0; n < 5000; n++) begin
         if ($urandom_range(0, 1499) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(0, 15) != 0, $urandom_range(0, 299) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 8191)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
